// File: rtl/awmc_panel.sv
// Front-panel operator controller for the washing-machine controller.
// Latency: raw button rise to command change is 2 (sync) + DEB_CYCLES + 1 cycles; all outputs registered.
// Backpressure: none; events not acted on in the current state are dropped, never queued.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   btn_start/btn_pause/btn_cancel raw asynchronous panel buttons (active high)
//   stage[2:0], done               controller status (stage 0 = idle)
//   start, pause, ctl_reset        command outputs to the controller
//   buzzer, fault, stage_led[2:0]  operator indications
//   lock                           child lock, present only when PANEL_CHILD_LOCK_EN is defined
module awmc_panel #(
    parameter int DEB_CYCLES    = 16,
    parameter int START_HOLD    = 2,
    parameter int BUZZ_CYCLES   = 1000,
    parameter int STAGE_TIMEOUT = 100000,
    parameter int CW            = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_cancel,
`ifdef PANEL_CHILD_LOCK_EN
    input  logic       lock,
`endif
    input  logic [2:0] stage,
    input  logic       done,
    output logic       start,
    output logic       pause,
    output logic       ctl_reset,
    output logic       buzzer,
    output logic       fault,
    output logic [2:0] stage_led
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTING,
        S_RUNNING,
        S_PAUSED,
        S_FINISHED,
        S_FAULT
    } state_t;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEB_TH  = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] HOLD_TH = CW'(START_HOLD);
    localparam logic [CW-1:0] BUZZ_TH = CW'(BUZZ_CYCLES);
    localparam logic [CW-1:0] TO_TH   = CW'(STAGE_TIMEOUT);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // ---------------- button conditioning (bit 0 start, 1 pause, 2 cancel)
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_q, deb_d, deb_prev_q;
    logic [CW-1:0] deb_cnt_q [3];
    logic [CW-1:0] deb_cnt_d [3];
    logic [2:0]    press;

    assign raw = {btn_cancel, btn_pause, btn_start};

    // The counter only advances while the synchronised sample disagrees with
    // the accepted level; any agreeing sample restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (sat_inc(deb_cnt_q[i]) >= DEB_TH) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = sat_inc(deb_cnt_q[i]);
                end
            end
        end
    end

    // One-cycle press pulse, one cycle after the debounced level rises.
    assign press = deb_q & ~deb_prev_q;

    logic start_ev, pause_ev, cancel_ev;
    assign cancel_ev = press[2];
`ifdef PANEL_CHILD_LOCK_EN
    assign start_ev  = press[0] & ~lock;
    assign pause_ev  = press[1] & ~lock;
`else
    assign start_ev  = press[0];
    assign pause_ev  = press[1];
`endif

    // ---------------- operator FSM
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;          // shared: start hold, watchdog, buzzer
    logic [CW-1:0] cnt_inc, wd_next;
    logic [2:0]    stage_prev_q;
    logic          start_d, pause_d, ctl_reset_d, buzzer_d, fault_d;
    logic [2:0]    stage_led_d;
    logic          blink_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctl_reset_d = 1'b0;
        cnt_inc     = sat_inc(cnt_q);
        wd_next     = (stage != stage_prev_q) ? '0 : cnt_inc;

        // Branch order inside each state encodes the event priority:
        // cancel > done > watchdog timeout > pause > start.
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start_ev) state_d = S_STARTING;
            end
            S_STARTING: begin
                if (cancel_ev) begin
                    state_d     = S_IDLE;
                    ctl_reset_d = 1'b1;
                    cnt_d       = '0;
                end else if (cnt_inc >= HOLD_TH) begin
                    state_d = S_RUNNING;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUNNING: begin
                if (cancel_ev) begin
                    state_d     = S_IDLE;
                    ctl_reset_d = 1'b1;
                    cnt_d       = '0;
                end else if (done) begin
                    state_d = S_FINISHED;
                    cnt_d   = '0;
                end else if (wd_next >= TO_TH) begin
                    state_d     = S_FAULT;
                    ctl_reset_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    // Pausing keeps the watchdog value so the stall budget
                    // is not refreshed by a pause/resume.
                    cnt_d = wd_next;
                    if (pause_ev) state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (cancel_ev) begin
                    state_d     = S_IDLE;
                    ctl_reset_d = 1'b1;
                    cnt_d       = '0;
                end else if (pause_ev) begin
                    state_d = S_RUNNING;
                end
            end
            S_FINISHED: begin
                if (cancel_ev || (cnt_inc >= BUZZ_TH)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FAULT: begin
                cnt_d = '0;
                if (cancel_ev) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        start_d  = (state_d == S_STARTING);
        pause_d  = (state_d == S_PAUSED);
        buzzer_d = (state_d == S_FINISHED);
        fault_d  = (state_d == S_FAULT);
        stage_led_d = ((state_d == S_RUNNING) || (state_d == S_PAUSED)) ? stage : 3'd0;
`ifdef PANEL_CHILD_LOCK_EN
        if (lock && blink_q && (state_q != S_IDLE)) stage_led_d = 3'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stage_prev_q <= '0;
            blink_q      <= 1'b0;
            start        <= 1'b0;
            pause        <= 1'b0;
            ctl_reset    <= 1'b0;
            buzzer       <= 1'b0;
            fault        <= 1'b0;
            stage_led    <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_q;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_prev_q <= stage;
            blink_q      <= ~blink_q;
            start        <= start_d;
            pause        <= pause_d;
            ctl_reset    <= ctl_reset_d;
            buzzer       <= buzzer_d;
            fault        <= fault_d;
            stage_led    <= stage_led_d;
        end
    end

endmodule

// File: tb/tb_awmc_panel.sv
// Directed bench for awmc_panel with small timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
// Cycle n of a scenario is the n-th rising edge after the stimulus change.
module tb_awmc_panel;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start, btn_pause, btn_cancel;
    logic [2:0] stage;
    logic       done;
    logic       start, pause, ctl_reset, buzzer, fault;
    logic [2:0] stage_led;
`ifdef PANEL_CHILD_LOCK_EN
    logic       lock;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    awmc_panel #(
        .DEB_CYCLES(4), .START_HOLD(2), .BUZZ_CYCLES(8),
        .STAGE_TIMEOUT(50), .CW(8)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_pause(btn_pause), .btn_cancel(btn_cancel),
`ifdef PANEL_CHILD_LOCK_EN
        .lock(lock),
`endif
        .stage(stage), .done(done),
        .start(start), .pause(pause), .ctl_reset(ctl_reset),
        .buzzer(buzzer), .fault(fault), .stage_led(stage_led)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; btn_cancel = 1'b0; done = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    // Start press held 10 cycles; RUNNING from cycle 9, then let the release settle.
    task automatic go_running();
        btn_start = 1'b1;
        tick(10);
        btn_start = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        stage = 3'd3; btn_start = 1'b0; btn_pause = 1'b0; btn_cancel = 1'b0; done = 1'b0;
        reset = 1'b1;
        tick(2);
        n_tests++; if (start !== 1'b0)     begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
        n_tests++; if (pause !== 1'b0)     begin n_fail++; $display("FAIL reset_pause got %b want 0", pause); end
        n_tests++; if (ctl_reset !== 1'b0) begin n_fail++; $display("FAIL reset_ctl_reset got %b want 0", ctl_reset); end
        n_tests++; if (buzzer !== 1'b0)    begin n_fail++; $display("FAIL reset_buzzer got %b want 0", buzzer); end
        n_tests++; if (fault !== 1'b0)     begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
        n_tests++; if (stage_led !== 3'd0) begin n_fail++; $display("FAIL reset_stage_led got %0d want 0", stage_led); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_start();
        logic exp_start;
        stage = 3'd1;
        do_reset();
        btn_start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick(1);
            exp_start = (n == 7) || (n == 8);
            n_tests++;
            if (start !== exp_start) begin
                n_fail++; $display("FAIL start_cycle%0d got %b want %b", n, start, exp_start);
            end
            if (n == 10) btn_start = 1'b0;
            if (ctl_reset !== 1'b0) begin
                n_fail++; $display("FAIL start_no_ctl_reset cycle%0d got %b want 0", n, ctl_reset);
            end
        end
        n_tests++;
        if (stage_led !== 3'd1) begin n_fail++; $display("FAIL start_running_led got %0d want 1", stage_led); end
    endtask

    task automatic test_pause_watchdog();
        bit seen;
        stage = 3'd1;
        do_reset();
        go_running();
        // Short glitch must be filtered out.
        seen = 0;
        btn_pause = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            tick(1);
            if (n == 3) btn_pause = 1'b0;
            if (pause) seen = 1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL pause_glitch got pause seen=%b want 0", seen); end
        // Stage step clears the watchdog at cycle 1; pause frozen from cycle 8 to 21.
        stage = 3'd2;
        btn_pause = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tick(1);
            if (n == 6)  begin btn_pause = 1'b0;
                n_tests++; if (pause !== 1'b0) begin n_fail++; $display("FAIL pause_before got %b want 0", pause); end end
            if (n == 7)  begin n_tests++; if (pause !== 1'b1) begin n_fail++; $display("FAIL pause_on got %b want 1", pause); end end
            if (n == 14) btn_pause = 1'b1;
            if (n == 20) begin btn_pause = 1'b0;
                n_tests++; if (pause !== 1'b1) begin n_fail++; $display("FAIL pause_held got %b want 1", pause); end end
            if (n == 21) begin n_tests++; if (pause !== 1'b0) begin n_fail++; $display("FAIL pause_resume got %b want 0", pause); end end
            if (n == 64) begin n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL wd_early got fault=%b want 0", fault); end end
            if (n == 65) begin
                n_tests++; if (fault !== 1'b1)     begin n_fail++; $display("FAIL wd_fault got %b want 1", fault); end
                n_tests++; if (ctl_reset !== 1'b1) begin n_fail++; $display("FAIL wd_ctl_reset got %b want 1", ctl_reset); end
            end
            if (n == 66) begin n_tests++; if (ctl_reset !== 1'b0) begin n_fail++; $display("FAIL wd_ctl_pulse got %b want 0", ctl_reset); end end
        end
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky got %b want 1", fault); end
        // Start/pause ignored in FAULT; cancel clears it.
        btn_cancel = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick(1);
            if (n == 6) begin btn_cancel = 1'b0;
                n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_pre_cancel got %b want 1", fault); end end
            if (n == 7) begin
                n_tests++; if (fault !== 1'b0)     begin n_fail++; $display("FAIL fault_cancel got %b want 0", fault); end
                n_tests++; if (ctl_reset !== 1'b0) begin n_fail++; $display("FAIL fault_cancel_ctl got %b want 0", ctl_reset); end
                n_tests++; if (stage_led !== 3'd0) begin n_fail++; $display("FAIL fault_cancel_led got %0d want 0", stage_led); end
            end
        end
    endtask

    task automatic test_done_buzzer();
        int buzz_cnt;
        stage = 3'd1;
        do_reset();
        go_running();
        tick(30); stage = 3'd2;
        tick(30); stage = 3'd3;
        tick(30);
        n_tests++; if (fault !== 1'b0)     begin n_fail++; $display("FAIL steps_no_fault got %b want 0", fault); end
        n_tests++; if (stage_led !== 3'd3) begin n_fail++; $display("FAIL steps_led got %0d want 3", stage_led); end
        done = 1'b1;
        buzz_cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            tick(1);
            if (n == 1) begin done = 1'b0;
                n_tests++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL buzz_first got %b want 1", buzzer); end end
            if (n == 9) begin
                n_tests++; if (buzzer !== 1'b0)    begin n_fail++; $display("FAIL buzz_end got %b want 0", buzzer); end
                n_tests++; if (stage_led !== 3'd0) begin n_fail++; $display("FAIL done_led got %0d want 0", stage_led); end
            end
            if (buzzer) buzz_cnt++;
        end
        n_tests++; if (buzz_cnt !== 8) begin n_fail++; $display("FAIL buzz_len got %0d want 8", buzz_cnt); end
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL done_no_fault got %b want 0", fault); end
    endtask

    task automatic test_cancel_pause();
        bit seen;
        stage = 3'd1;
        do_reset();
        go_running();
        seen = 0;
        btn_cancel = 1'b1; btn_pause = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick(1);
            if (pause) seen = 1;
            if (n == 6) begin btn_cancel = 1'b0; btn_pause = 1'b0;
                n_tests++; if (ctl_reset !== 1'b0) begin n_fail++; $display("FAIL cp_pre got %b want 0", ctl_reset); end end
            if (n == 7) begin
                n_tests++; if (ctl_reset !== 1'b1) begin n_fail++; $display("FAIL cp_ctl_reset got %b want 1", ctl_reset); end
                n_tests++; if (stage_led !== 3'd0) begin n_fail++; $display("FAIL cp_idle_led got %0d want 0", stage_led); end
            end
            if (n == 8) begin n_tests++; if (ctl_reset !== 1'b0) begin n_fail++; $display("FAIL cp_pulse got %b want 0", ctl_reset); end end
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cp_pause got seen=%b want 0", seen); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        stage = 3'd1;
        do_reset();
        btn_start = 1'b1;
        tick(7);
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL mid_starting got %b want 1", start); end
        reset = 1'b1; btn_start = 1'b0;
        tick(1);
        n_tests++; if (start !== 1'b0)     begin n_fail++; $display("FAIL mid_start got %b want 0", start); end
        n_tests++; if (ctl_reset !== 1'b0) begin n_fail++; $display("FAIL mid_ctl_reset got %b want 0", ctl_reset); end
        reset = 1'b0;
        tick(12);
        // In IDLE a pause press is ignored.
        seen = 0;
        btn_pause = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick(1);
            if (n == 6) btn_pause = 1'b0;
            if (pause || start || (stage_led != 3'd0)) seen = 1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_idle got activity=%b want 0", seen); end
    endtask

`ifdef PANEL_CHILD_LOCK_EN
    task automatic test_lock();
        bit seen;
        stage = 3'd1;
        lock = 1'b1;
        do_reset();
        seen = 0;
        btn_start = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick(1);
            if (n == 10) btn_start = 1'b0;
            if (start || (stage_led != 3'd0)) seen = 1;
        end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL lock_start got activity=%b want 0", seen); end
        lock = 1'b0;
    endtask
`endif

    initial begin
`ifdef PANEL_CHILD_LOCK_EN
        lock = 1'b0;
`endif
        test_reset();
        test_start();
        test_pause_watchdog();
        test_done_buzzer();
        test_cancel_pause();
        test_reset_mid();
`ifdef PANEL_CHILD_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
